ldm_stm_sequencer: RTL and testbench

Multi-cycle sequencer for block transfers (LDM/STM) in the ARM datapath. It sits directly upstream of the register file. It walks a 16-bit register list in ascending order and drives the register-file read port 2 and write port 3, plus the data-memory address, write-enable and write-data. It stalls the main controller while it runs.

---
 rtl/arm_pkg.sv | 31 +++
 rtl/priority_enc16.sv | 20 ++
 rtl/ldm_stm_sequencer.sv | 151 +++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: block-transfer addressing modes, sequencer
// state encoding and the register-list popcount helper.
package arm_pkg;

    // Encoded as {pre, up} so the mode can be cast directly from the P/U bits.
    typedef enum logic [1:0] {
        DA = 2'b00,
        IA = 2'b01,
        DB = 2'b10,
        IB = 2'b11
    } block_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        XFER  = 2'b01,
        WBACK = 2'b10,
        DONE  = 2'b11
    } seq_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/priority_enc16.sv
// Lowest-set-bit encoder over a 16-bit vector; valid is low for an all-zero input.
module priority_enc16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);

    always_comb begin
        idx   = 4'd0;
        valid = 1'b0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = i[3:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first, one
// register per cycle, then optionally writes the updated base back to rn.
module ldm_stm_sequencer
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic [15:0] reglist,
    input  logic [31:0] rd2,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic [3:0]  ra2,
    output logic [3:0]  wa3,
    output logic        we3,
    output logic [31:0] wd3,
    output logic        pc_load
);

    seq_state_t  state_reg, state_next;
    logic [15:0] list_reg;
    logic [31:0] addr_reg;
    logic [31:0] hold_reg;
    logic [31:0] final_reg;
    logic [3:0]  rn_reg;
    logic        is_load_reg;
    logic        wb_en_reg;

    logic [4:0]  cnt;
    logic [31:0] four_cnt;
    logic [31:0] start_addr;
    logic        wb_en;
    block_mode_t mode;
    logic [3:0]  cur_idx;
    logic        cur_valid;
    logic [15:0] list_left;

    priority_enc16 u_penc (
        .vec   (list_reg),
        .idx   (cur_idx),
        .valid (cur_valid)
    );

    assign cnt       = popcount(reglist);
    assign four_cnt  = {25'd0, cnt, 2'b00};
    assign mode      = block_mode_t'({pre, up});
    assign list_left = list_reg & ~(16'd1 << cur_idx);
    // A loaded rn wins over the writeback, and the PC is never a writeback target.
    assign wb_en     = wback && !(is_load && reglist[rn]) && (rn != REG_PC);

    always_comb begin
        start_addr = base;
        case (mode)
            IA: start_addr = base;
            IB: start_addr = base + 32'd4;
            DA: start_addr = base - four_cnt + 32'd4;
            DB: start_addr = base - four_cnt;
            default: start_addr = base;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = (cnt != 5'd0) ? XFER : DONE;
            XFER:    if (!cur_valid || list_left == 16'd0) state_next = wb_en_reg ? WBACK : DONE;
            WBACK:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            list_reg    <= 16'd0;
            addr_reg    <= 32'd0;
            hold_reg    <= 32'd0;
            final_reg   <= 32'd0;
            rn_reg      <= 4'd0;
            is_load_reg <= 1'b0;
            wb_en_reg   <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            list_reg    <= reglist;
            addr_reg    <= start_addr;
            final_reg   <= up ? (base + four_cnt) : (base - four_cnt);
            rn_reg      <= rn;
            is_load_reg <= is_load;
            wb_en_reg   <= wb_en;
        end else if (state_reg == XFER) begin
            list_reg <= list_left;
            addr_reg <= addr_reg + 32'd4;
            hold_reg <= addr_reg;
        end
    end

    // Outside a transfer the address bus keeps showing the last address used.
    assign mem_addr  = (state_reg == XFER) ? addr_reg : hold_reg;
    assign mem_wdata = rd2;

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        mem_we  = 1'b0;
        we3     = 1'b0;
        pc_load = 1'b0;
        ra2     = 4'd0;
        wa3     = 4'd0;
        wd3     = 32'd0;
        case (state_reg)
            XFER: begin
                busy = 1'b1;
                if (is_load_reg) begin
                    wa3 = cur_idx;
                    wd3 = mem_rdata;
                    if (cur_idx == REG_PC) pc_load = 1'b1;
                    else                   we3     = 1'b1;
                end else begin
                    ra2    = cur_idx;
                    mem_we = 1'b1;
                end
            end
            WBACK: begin
                busy = 1'b1;
                we3  = 1'b1;
                wa3  = rn_reg;
                wd3  = final_reg;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a tiny register file and memory model.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_load, up, pre, wback;
    logic [3:0]  rn;
    logic [31:0] base;
    logic [15:0] reglist;
    logic [31:0] rd2, mem_rdata;
    logic        busy, done, mem_we, we3, pc_load;
    logic [31:0] mem_addr, mem_wdata, wd3;
    logic [3:0]  ra2, wa3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Register Rn holds 0xA0+n; memory word at address a reads 0xD0000000|a.
    assign rd2       = 32'h0000_00A0 + {28'd0, ra2};
    assign mem_rdata = 32'hD000_0000 | mem_addr;

    ldm_stm_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .up(up),
        .pre(pre), .wback(wback), .rn(rn), .base(base), .reglist(reglist),
        .rd2(rd2), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .ra2(ra2),
        .wa3(wa3), .we3(we3), .wd3(wd3), .pc_load(pc_load)
    );

    // Issues start during T0 and returns at the falling edge inside T1.
    task automatic start_op(input logic ld, input logic u, input logic p, input logic w,
                            input logic [3:0] r, input logic [31:0] b, input logic [15:0] rl);
        @(negedge clk);
        is_load = ld; up = u; pre = p; wback = w; rn = r; base = b; reglist = rl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b1; pre = 1'b0; wback = 1'b0;
        rn = 4'd0; base = 32'd0; reglist = 16'd0;
        #12;
        tests++;
        if ({busy, done, mem_we, we3, pc_load} !== 5'b00000 || mem_addr !== 32'd0 ||
            ra2 !== 4'd0 || wa3 !== 4'd0 || wd3 !== 32'd0) begin
            fails++;
            $display("FAIL reset: flags=%b addr=%h ra2=%0d wa3=%0d wd3=%h, required 00000/0/0/0/0",
                     {busy, done, mem_we, we3, pc_load}, mem_addr, ra2, wa3, wd3);
        end
        $display("[TB] reset state checked");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stm_ia();
        start_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h100, 16'h000F);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if ({busy, done, mem_we, we3, pc_load} !== 5'b10100 || mem_addr !== 32'h100 + 4 * k ||
                mem_wdata !== 32'hA0 + k || ra2 !== k[3:0]) begin
                fails++;
                $display("FAIL stm_ia_xfer%0d: flags=%b addr=%h wdata=%h, required 10100 addr=%h wdata=%h",
                         k, {busy, done, mem_we, we3, pc_load}, mem_addr, mem_wdata, 32'h100 + 4 * k, 32'hA0 + k);
            end
            $display("[TB] stm_ia store %0d addr=%h data=%h", k, mem_addr, mem_wdata);
            @(negedge clk);
        end
        tests++;
        if ({busy, done, mem_we, we3, pc_load} !== 5'b10010 || wa3 !== 4'd5 || wd3 !== 32'h110) begin
            fails++;
            $display("FAIL stm_ia_wback: flags=%b wa3=%0d wd3=%h, required 10010 wa3=5 wd3=00000110",
                     {busy, done, mem_we, we3, pc_load}, wa3, wd3);
        end
        $display("[TB] stm_ia writeback R%0d=%h", wa3, wd3);
        @(negedge clk);
        tests++;
        if ({busy, done, mem_we, we3, pc_load} !== 5'b01000) begin
            fails++;
            $display("FAIL stm_ia_done_t6: flags=%b, required 01000", {busy, done, mem_we, we3, pc_load});
        end
        $display("[TB] stm_ia done at T6");
        @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL stm_ia_idle: busy/done=%b, required 00", {busy, done});
        end
    endtask

    task automatic test_ldm_db();
        logic [3:0]  exp_wa [3];
        logic [31:0] exp_ad [3];
        exp_wa[0] = 4'd1; exp_wa[1] = 4'd4; exp_wa[2] = 4'd15;
        exp_ad[0] = 32'h1F4; exp_ad[1] = 32'h1F8; exp_ad[2] = 32'h1FC;
        start_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h200, 16'h8012);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (k < 2) begin
                if ({busy, done, mem_we, we3, pc_load} !== 5'b10010 || mem_addr !== exp_ad[k] ||
                    wa3 !== exp_wa[k] || wd3 !== (32'hD000_0000 | exp_ad[k])) begin
                    fails++;
                    $display("FAIL ldm_db_load%0d: flags=%b addr=%h wa3=%0d wd3=%h, required 10010 addr=%h wa3=%0d",
                             k, {busy, done, mem_we, we3, pc_load}, mem_addr, wa3, wd3, exp_ad[k], exp_wa[k]);
                end
            end else begin
                if ({busy, done, mem_we, we3, pc_load} !== 5'b10001 || mem_addr !== exp_ad[k] ||
                    wd3 !== (32'hD000_0000 | exp_ad[k])) begin
                    fails++;
                    $display("FAIL ldm_db_pc: flags=%b addr=%h wd3=%h, required 10001 addr=%h",
                             {busy, done, mem_we, we3, pc_load}, mem_addr, wd3, exp_ad[k]);
                end
            end
            $display("[TB] ldm_db load %0d addr=%h data=%h", k, mem_addr, wd3);
            // A start while busy must be ignored.
            start = (k == 0);
            reglist = (k == 0) ? 16'hFFFF : 16'h8012;
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if ({busy, done, mem_we, we3, pc_load} !== 5'b10010 || wa3 !== 4'd13 || wd3 !== 32'h1F4) begin
            fails++;
            $display("FAIL ldm_db_wback: flags=%b wa3=%0d wd3=%h, required 10010 wa3=13 wd3=000001f4",
                     {busy, done, mem_we, we3, pc_load}, wa3, wd3);
        end
        $display("[TB] ldm_db writeback R%0d=%h", wa3, wd3);
        @(negedge clk);
        tests++;
        if ({busy, done, mem_we, we3, pc_load} !== 5'b01000) begin
            fails++;
            $display("FAIL ldm_db_done: flags=%b, required 01000", {busy, done, mem_we, we3, pc_load});
        end
        @(negedge clk);
        tests++;
        if ({busy, done, mem_we, we3} !== 4'b0000) begin
            fails++;
            $display("FAIL ldm_db_ignored_start: flags=%b, required 0000", {busy, done, mem_we, we3});
        end
    endtask

    task automatic test_ldm_rn_in_list();
        start_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h0006);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({busy, done, we3} !== 3'b101 || wa3 !== k[3:0] + 4'd1 ||
                wd3 !== (32'hD000_0300 + 4 * k)) begin
                fails++;
                $display("FAIL ldm_rn_load%0d: busy/done/we3=%b wa3=%0d wd3=%h, required 101 wa3=%0d wd3=%h",
                         k, {busy, done, we3}, wa3, wd3, k + 1, 32'hD000_0300 + 4 * k);
            end
            $display("[TB] ldm_rn load R%0d=%h", wa3, wd3);
            @(negedge clk);
        end
        tests++;
        if ({busy, done, we3} !== 3'b010) begin
            fails++;
            $display("FAIL ldm_rn_no_wback: busy/done/we3=%b, required 010", {busy, done, we3});
        end
        @(negedge clk);
    endtask

    task automatic test_empty_list();
        @(negedge clk);
        is_load = 1'b0; up = 1'b1; pre = 1'b0; wback = 1'b1; rn = 4'd3; base = 32'h40; reglist = 16'h0000;
        start = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL empty_t0_busy: busy=%b, required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if ({busy, done, mem_we, we3, pc_load} !== 5'b01000) begin
            fails++;
            $display("FAIL empty_done_t1: flags=%b, required 01000", {busy, done, mem_we, we3, pc_load});
        end
        $display("[TB] empty list done at T1");
        @(negedge clk);
    endtask

    task automatic test_stm_da();
        start_op(1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 32'h0000_0004, 16'h0003);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (mem_we !== 1'b1 || mem_addr !== 32'd4 * k || mem_wdata !== 32'hA0 + k) begin
                fails++;
                $display("FAIL stm_da_store%0d: we=%b addr=%h wdata=%h, required 1 addr=%h wdata=%h",
                         k, mem_we, mem_addr, mem_wdata, 32'd4 * k, 32'hA0 + k);
            end
            $display("[TB] stm_da store %0d addr=%h data=%h", k, mem_addr, mem_wdata);
            @(negedge clk);
        end
        tests++;
        if ({busy, done, mem_we, we3} !== 4'b0100) begin
            fails++;
            $display("FAIL stm_da_done: flags=%b, required 0100", {busy, done, mem_we, we3});
        end
        @(negedge clk);
    endtask

    task automatic test_rn_pc_suppressed();
        start_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 32'h0, 16'h0001);
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0) begin
            fails++;
            $display("FAIL rn_pc_store: we=%b addr=%h, required 1 addr=00000000", mem_we, mem_addr);
        end
        @(negedge clk);
        tests++;
        if ({busy, done, we3} !== 3'b010) begin
            fails++;
            $display("FAIL rn_pc_no_wback: busy/done/we3=%b, required 010", {busy, done, we3});
        end
        $display("[TB] rn=R15 writeback suppressed");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 32'h400, 16'h00FF);
        tests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h400) begin
            fails++;
            $display("FAIL midrst_t1: we=%b addr=%h, required 1 addr=00000400", mem_we, mem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, done, mem_we, we3, pc_load} !== 5'b00000) begin
            fails++;
            $display("FAIL midrst_async: flags=%b, required 00000", {busy, done, mem_we, we3, pc_load});
        end
        $display("[TB] reset asserted in T2");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, mem_we, we3} !== 3'b000) begin
            fails++;
            $display("FAIL midrst_stays_idle: busy/we/we3=%b, required 000", {busy, mem_we, we3});
        end
        start_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h500, 16'h0001);
        tests++;
        if ({busy, mem_we} !== 2'b11 || mem_addr !== 32'h504 || mem_wdata !== 32'hA0) begin
            fails++;
            $display("FAIL midrst_restart: busy/we=%b addr=%h wdata=%h, required 11 addr=00000504 wdata=000000a0",
                     {busy, mem_we}, mem_addr, mem_wdata);
        end
        $display("[TB] restart store addr=%h data=%h", mem_addr, mem_wdata);
        @(negedge clk);
        tests++;
        if ({busy, done, mem_we} !== 3'b010) begin
            fails++;
            $display("FAIL midrst_restart_done: flags=%b, required 010", {busy, done, mem_we});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stm_ia();
        test_ldm_db();
        test_ldm_rn_in_list();
        test_empty_list();
        test_stm_da();
        test_rn_pc_suppressed();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
